// File: rtl/rc4_stream_core_if.sv
// Key-load, control/status and streaming handshake signals of the RC4 core.
// master drives keys, start and input symbols; slave is the core.
interface rc4_stream_core_if #(
    parameter int W       = 4,
    parameter int KEY_MAX = 16
);
    localparam int KAW = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;
    localparam int KLW = $clog2(KEY_MAX + 1);

    logic           key_wr;
    logic [KAW-1:0] key_addr;
    logic [W-1:0]   key_data;
    logic [KLW-1:0] key_len;
    logic           start;
    logic           busy;
    logic           keyed;
    logic           err;
    logic [W-1:0]   din;
    logic           din_valid;
    logic           din_ready;
    logic [W-1:0]   dout;
    logic           dout_valid;
    logic           dout_ready;

    modport master (
        output key_wr, key_addr, key_data, key_len, start, din, din_valid, dout_ready,
        input  busy, keyed, err, din_ready, dout, dout_valid
    );

    modport slave (
        input  key_wr, key_addr, key_data, key_len, start, din, din_valid, dout_ready,
        output busy, keyed, err, din_ready, dout, dout_valid
    );
endinterface

// File: rtl/rc4_stream_core.sv
// RC4 engine with W-bit symbols: key scheduling, optional keystream drop, then
// one keystream symbol XORed onto each accepted input symbol.
module rc4_stream_core #(
    parameter int W       = 4,
    parameter int KEY_MAX = 16,
    parameter int DROP    = 0
) (
    input logic           clk,
    input logic           reset,
    rc4_stream_core_if.slave bus
);
    localparam int N   = 1 << W;
    localparam int KAW = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;
    localparam int KLW = $clog2(KEY_MAX + 1);
    localparam int DCW = (DROP > 1) ? $clog2(DROP) : 1;
    localparam logic [DCW-1:0] DROP_LAST = DCW'((DROP > 0) ? DROP - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_KSA, S_DROP, S_RUN} state_t;
    state_t state, state_nx;

    logic [W-1:0]   sbox [N];
    logic [W-1:0]   kbuf [KEY_MAX];
    logic [W-1:0]   i, j;
    logic [KAW-1:0] kidx;
    logic [KLW-1:0] key_len_q;
    logic [DCW-1:0] drop_cnt;

    logic         len_ok, start_ok, ksa_last, kidx_last, fire, prga_step;
    logic [W-1:0] j_ksa, i1, j1, si1, sj1, t_idx, ks;

    assign len_ok    = (bus.key_len != '0) && (bus.key_len <= KLW'(KEY_MAX));
    assign start_ok  = bus.start && len_ok && (state == S_IDLE || state == S_RUN);
    assign ksa_last  = (i == '1);
    assign kidx_last = ((KLW'(kidx) + KLW'(1)) == key_len_q);
    assign j_ksa     = j + sbox[i] + kbuf[kidx];

    // PRGA step; the keystream index is the same sum before and after the swap,
    // only the lookup has to see the swapped entries.
    assign i1    = i + W'(1);
    assign si1   = sbox[i1];
    assign j1    = j + si1;
    assign sj1   = sbox[j1];
    assign t_idx = si1 + sj1;

    always_comb begin
        ks = sbox[t_idx];
        if (t_idx == i1)      ks = sj1;
        else if (t_idx == j1) ks = si1;
    end

    assign bus.din_ready = bus.keyed & (~bus.dout_valid | bus.dout_ready);
    assign fire          = bus.din_valid & bus.din_ready;
    assign prga_step     = (state == S_DROP) || (state == S_RUN && fire);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start_ok) state_nx = S_INIT;
            S_INIT: state_nx = S_KSA;
            S_KSA:  if (ksa_last) state_nx = (DROP > 0) ? S_DROP : S_RUN;
            S_DROP: if (drop_cnt == DROP_LAST) state_nx = S_RUN;
            S_RUN:  if (start_ok) state_nx = S_INIT;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = (state == S_INIT) || (state == S_KSA) || (state == S_DROP);
        bus.keyed = (state == S_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i              <= '0;
            j              <= '0;
            kidx           <= '0;
            key_len_q      <= '0;
            drop_cnt       <= '0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            bus.err <= bus.start && !len_ok && (state == S_IDLE || state == S_RUN);
            case (state)
                S_IDLE: if (start_ok) key_len_q <= bus.key_len;
                S_INIT: begin
                    i              <= '0;
                    j              <= '0;
                    kidx           <= '0;
                    drop_cnt       <= '0;
                    bus.dout_valid <= 1'b0;
                end
                S_KSA: begin
                    i    <= i + W'(1);
                    j    <= ksa_last ? '0 : j_ksa;
                    kidx <= kidx_last ? '0 : kidx + KAW'(1);
                end
                S_DROP: begin
                    i        <= i1;
                    j        <= j1;
                    drop_cnt <= drop_cnt + DCW'(1);
                end
                S_RUN: begin
                    if (start_ok) begin
                        key_len_q      <= bus.key_len;
                        bus.dout_valid <= 1'b0;
                    end else if (fire) begin
                        i              <= i1;
                        j              <= j1;
                        bus.dout       <= bus.din ^ ks;
                        bus.dout_valid <= 1'b1;
                    end else if (bus.dout_ready) begin
                        bus.dout_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // S-box and key buffer carry no reset: INIT and key writes define them.
    always_ff @(posedge clk) begin
        if (bus.key_wr && state == S_IDLE && int'(bus.key_addr) < KEY_MAX)
            kbuf[bus.key_addr] <= bus.key_data;
        if (state == S_INIT) begin
            for (int k = 0; k < N; k++) sbox[k] <= W'(k);
        end else if (state == S_KSA) begin
            sbox[i]     <= sbox[j_ksa];
            sbox[j_ksa] <= sbox[i];
        end else if (prga_step) begin
            sbox[i1] <= sj1;
            sbox[j1] <= si1;
        end
    end
endmodule

// File: tb/tb_rc4_stream_core.sv
// Directed bench for rc4_stream_core: three instances (W=8, W=8 with DROP=4,
// W=4) share broadcast stimulus; sel picks whose outputs are observed.
module tb_rc4_stream_core;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rc4_stream_core_if #(.W(8), .KEY_MAX(16)) bus_a ();
    rc4_stream_core_if #(.W(8), .KEY_MAX(16)) bus_d ();
    rc4_stream_core_if #(.W(4), .KEY_MAX(16)) bus_n ();

    rc4_stream_core #(.W(8), .KEY_MAX(16), .DROP(0)) u_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
    rc4_stream_core #(.W(8), .KEY_MAX(16), .DROP(4)) u_d (.clk(clk), .reset(reset), .bus(bus_d.slave));
    rc4_stream_core #(.W(4), .KEY_MAX(16), .DROP(0)) u_n (.clk(clk), .reset(reset), .bus(bus_n.slave));

    logic       key_wr, start, din_valid, dout_ready;
    logic [3:0] key_addr;
    logic [7:0] key_data, din;
    logic [4:0] key_len;

    assign bus_a.key_wr = key_wr;     assign bus_d.key_wr = key_wr;     assign bus_n.key_wr = key_wr;
    assign bus_a.key_addr = key_addr; assign bus_d.key_addr = key_addr; assign bus_n.key_addr = key_addr;
    assign bus_a.key_data = key_data; assign bus_d.key_data = key_data; assign bus_n.key_data = key_data[3:0];
    assign bus_a.key_len = key_len;   assign bus_d.key_len = key_len;   assign bus_n.key_len = key_len;
    assign bus_a.start = start;       assign bus_d.start = start;       assign bus_n.start = start;
    assign bus_a.din = din;           assign bus_d.din = din;           assign bus_n.din = din[3:0];
    assign bus_a.din_valid = din_valid;   assign bus_d.din_valid = din_valid;   assign bus_n.din_valid = din_valid;
    assign bus_a.dout_ready = dout_ready; assign bus_d.dout_ready = dout_ready; assign bus_n.dout_ready = dout_ready;

    int         sel;
    logic       o_busy, o_keyed, o_err, o_din_ready, o_dout_valid;
    logic [7:0] o_dout;

    always_comb begin
        o_busy = bus_a.busy; o_keyed = bus_a.keyed; o_err = bus_a.err;
        o_din_ready = bus_a.din_ready; o_dout_valid = bus_a.dout_valid; o_dout = bus_a.dout;
        if (sel == 1) begin
            o_busy = bus_d.busy; o_keyed = bus_d.keyed; o_err = bus_d.err;
            o_din_ready = bus_d.din_ready; o_dout_valid = bus_d.dout_valid; o_dout = bus_d.dout;
        end else if (sel == 2) begin
            o_busy = bus_n.busy; o_keyed = bus_n.keyed; o_err = bus_n.err;
            o_din_ready = bus_n.din_ready; o_dout_valid = bus_n.dout_valid; o_dout = {4'h0, bus_n.dout};
        end
    end

    int checks = 0;
    int failures = 0;
    int mkey[16];
    int tx[64];
    int rx[64];
    int nrx;

    // textbook RC4 reference over 2^w entries
    int ms[256];
    int mi, mj, mn;

    function automatic int model_next();
        int t;
        mi = (mi + 1) % mn;
        mj = (mj + ms[mi]) % mn;
        t = ms[mi]; ms[mi] = ms[mj]; ms[mj] = t;
        return ms[(ms[mi] + ms[mj]) % mn];
    endfunction

    function automatic void model_init(input int w, input int klen, input int drop);
        int jj, t;
        mn = 1 << w;
        for (int k = 0; k < mn; k++) ms[k] = k;
        jj = 0;
        for (int k = 0; k < mn; k++) begin
            jj = (jj + ms[k] + mkey[k % klen]) % mn;
            t = ms[k]; ms[k] = ms[jj]; ms[jj] = t;
        end
        mi = 0; mj = 0;
        for (int d = 0; d < drop; d++) void'(model_next());
    endfunction

    task automatic go_idle();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic load_key(input int n);
        go_idle();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            key_wr = 1'b1; key_addr = 4'(k); key_data = 8'(mkey[k]);
        end
        @(negedge clk); key_wr = 1'b0;
    endtask

    // start pulse, then cycles until keyed (2000 means it never came)
    task automatic do_start(input int klen, output int lat, output bit both_hi, output bit busy1);
        bit done;
        @(negedge clk);
        key_len = 5'(klen); start = 1'b1;
        lat = 0; done = 1'b0; both_hi = 1'b0; busy1 = 1'b0;
        while (!done && lat < 2000) begin
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (lat == 1) busy1 = o_busy;
            if (o_busy && o_keyed) both_hi = 1'b1;
            if (o_keyed) done = 1'b1;
        end
        if (!done) lat = 2000;
    endtask

    // pushes tx[0..n-1], collects rx; counts violations of the stall contract
    task automatic stream(input int n, input bit rnd, output int cycles, output int stall_bad);
        int sent;
        bit stalled;
        logic [7:0] held;
        sent = 0; nrx = 0; cycles = 0; stall_bad = 0; stalled = 1'b0; held = '0;
        while (nrx < n && cycles < 1000) begin
            @(negedge clk);
            din_valid = (sent < n);
            din = (sent < n) ? 8'(tx[sent]) : 8'h00;
            dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (stalled && (!o_dout_valid || o_dout !== held)) stall_bad++;
            if (din_valid && o_din_ready) sent++;
            if (o_dout_valid && dout_ready) begin rx[nrx] = int'(o_dout); nrx++; end
            stalled = o_dout_valid && !dout_ready;
            if (stalled && o_din_ready) stall_bad++;
            held = o_dout;
            cycles++;
        end
        @(negedge clk); din_valid = 1'b0; dout_ready = 1'b1;
    endtask

    task automatic test_reset();
        sel = 0;
        #2;
        checks++; if (o_dout !== 8'h00) begin failures++; $display("FAIL reset_dout: got %0h want 0", o_dout); end
        checks++; if ({o_dout_valid, o_din_ready, o_busy, o_keyed, o_err} !== 5'b0) begin
            failures++; $display("FAIL reset_flags: got %b want 00000", {o_dout_valid, o_din_ready, o_busy, o_keyed, o_err});
        end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_key_stream();
        int lat, cyc, bad;
        bit both, b1;
        int exp_ks[10] = '{'hEB, 'h9F, 'h77, 'h81, 'hB7, 'h34, 'hCA, 'h72, 'hA7, 'h19};
        sel = 0;
        mkey[0] = 'h4B; mkey[1] = 'h65; mkey[2] = 'h79;
        load_key(3);
        do_start(3, lat, both, b1);
        checks++; if (lat != 258) begin failures++; $display("FAIL key_latency: got %0d want 258", lat); end
        checks++; if (!b1) begin failures++; $display("FAIL busy_after_start: got 0 want 1"); end
        checks++; if (both) begin failures++; $display("FAIL busy_keyed_overlap: got 1 want 0"); end
        for (int k = 0; k < 10; k++) tx[k] = 0;
        stream(10, 1'b0, cyc, bad);
        checks++; if (cyc != 11) begin failures++; $display("FAIL key_throughput: got %0d cycles want 11", cyc); end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (rx[k] != exp_ks[k]) begin failures++; $display("FAIL key_ks[%0d]: got %0h want %0h", k, rx[k], exp_ks[k]); end
        end
    endtask

    task automatic test_wiki();
        int lat, cyc, bad;
        bit both, b1;
        int pt[5] = '{'h70, 'h65, 'h64, 'h69, 'h61};
        int ct[5] = '{'h10, 'h21, 'hBF, 'h04, 'h20};
        sel = 0;
        mkey[0] = 'h57; mkey[1] = 'h69; mkey[2] = 'h6B; mkey[3] = 'h69;
        load_key(4);
        do_start(4, lat, both, b1);
        for (int k = 0; k < 5; k++) tx[k] = pt[k];
        stream(5, 1'b0, cyc, bad);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (rx[k] != ct[k]) begin failures++; $display("FAIL wiki_enc[%0d]: got %0h want %0h", k, rx[k], ct[k]); end
        end
        // re-key straight from RUN with the same buffered key
        do_start(4, lat, both, b1);
        checks++; if (lat != 258) begin failures++; $display("FAIL rekey_latency: got %0d want 258", lat); end
        for (int k = 0; k < 5; k++) tx[k] = ct[k];
        stream(5, 1'b0, cyc, bad);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (rx[k] != pt[k]) begin failures++; $display("FAIL wiki_dec[%0d]: got %0h want %0h", k, rx[k], pt[k]); end
        end
    endtask

    task automatic test_err();
        int bad_len[2] = '{0, 17};
        sel = 0;
        go_idle();
        for (int t = 0; t < 2; t++) begin
            @(negedge clk); key_len = 5'(bad_len[t]); start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
            checks++; if (o_err !== 1'b1 || o_busy !== 1'b0) begin
                failures++; $display("FAIL err_pulse len=%0d: got err=%b busy=%b want 1 0", bad_len[t], o_err, o_busy);
            end
            @(posedge clk); #1;
            checks++; if ({o_err, o_busy, o_keyed} !== 3'b000) begin
                failures++; $display("FAIL err_after len=%0d: got %b want 000", bad_len[t], {o_err, o_busy, o_keyed});
            end
        end
    endtask

    task automatic test_drop();
        int lat, cyc, bad, e;
        bit both, b1;
        sel = 1;
        mkey[0] = 'h4B; mkey[1] = 'h65; mkey[2] = 'h79;
        load_key(3);
        do_start(3, lat, both, b1);
        checks++; if (lat != 262) begin failures++; $display("FAIL drop_latency: got %0d want 262", lat); end
        tx[0] = 0;
        stream(1, 1'b0, cyc, bad);
        checks++; if (rx[0] != 'hB7) begin failures++; $display("FAIL drop_first: got %0h want b7", rx[0]); end
        model_init(8, 3, 5);
        for (int k = 0; k < 40; k++) tx[k] = int'($urandom_range(0, 255));
        stream(40, 1'b1, cyc, bad);
        checks++; if (nrx != 40) begin failures++; $display("FAIL drop_count: got %0d want 40", nrx); end
        checks++; if (bad != 0) begin failures++; $display("FAIL stall_hold: got %0d violations want 0", bad); end
        for (int k = 0; k < 40; k++) begin
            e = tx[k] ^ model_next();
            checks++;
            if (rx[k] != e) begin failures++; $display("FAIL drop_stream[%0d]: got %0h want %0h", k, rx[k], e); end
        end
    endtask

    task automatic test_w4();
        int lat, cyc, bad, e, klen[2] = '{16, 5};
        bit both, b1;
        sel = 2;
        for (int t = 0; t < 2; t++) begin
            for (int k = 0; k < klen[t]; k++) mkey[k] = int'($urandom_range(0, 15));
            load_key(klen[t]);
            do_start(klen[t], lat, both, b1);
            checks++; if (lat != 18) begin failures++; $display("FAIL w4_latency len=%0d: got %0d want 18", klen[t], lat); end
            model_init(4, klen[t], 0);
            for (int k = 0; k < 64; k++) tx[k] = int'($urandom_range(0, 15));
            stream(64, 1'b0, cyc, bad);
            for (int k = 0; k < 64; k++) begin
                e = tx[k] ^ model_next();
                checks++;
                if (rx[k] != e) begin failures++; $display("FAIL w4_stream len=%0d [%0d]: got %0h want %0h", klen[t], k, rx[k], e); end
            end
        end
    endtask

    task automatic test_reset_midop();
        int lat, cyc, bad;
        bit both, b1;
        int exp_ks[3] = '{'hEB, 'h9F, 'h77};
        sel = 0;
        mkey[0] = 'h4B; mkey[1] = 'h65; mkey[2] = 'h79;
        load_key(3);
        @(negedge clk); key_len = 5'd3; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL ksa_busy: got %b want 1", o_busy); end
        reset = 1'b1; #1;
        checks++; if ({o_busy, o_keyed, o_dout_valid, o_din_ready, o_err} !== 5'b0 || o_dout !== 8'h00) begin
            failures++; $display("FAIL ksa_async_reset: got %b dout=%0h want 0", {o_busy, o_keyed, o_dout_valid, o_din_ready, o_err}, o_dout);
        end
        @(negedge clk); reset = 1'b0;
        do_start(3, lat, both, b1);
        @(negedge clk); din = 8'h00; din_valid = 1'b1; dout_ready = 1'b0;
        @(negedge clk); din_valid = 1'b0; #1;
        checks++; if (o_dout_valid !== 1'b1 || o_din_ready !== 1'b0) begin
            failures++; $display("FAIL stall_state: got valid=%b ready=%b want 1 0", o_dout_valid, o_din_ready);
        end
        #1; reset = 1'b1; #1;
        checks++; if ({o_busy, o_keyed, o_dout_valid, o_din_ready, o_err} !== 5'b0 || o_dout !== 8'h00) begin
            failures++; $display("FAIL run_async_reset: got %b dout=%0h want 0", {o_busy, o_keyed, o_dout_valid, o_din_ready, o_err}, o_dout);
        end
        @(negedge clk); reset = 1'b0; dout_ready = 1'b1;
        load_key(3);
        do_start(3, lat, both, b1);
        for (int k = 0; k < 3; k++) tx[k] = 0;
        stream(3, 1'b0, cyc, bad);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rx[k] != exp_ks[k]) begin failures++; $display("FAIL post_reset_ks[%0d]: got %0h want %0h", k, rx[k], exp_ks[k]); end
        end
    endtask

    initial begin
        reset = 1'b1; sel = 0;
        key_wr = 1'b0; key_addr = '0; key_data = '0; key_len = '0; start = 1'b0;
        din = '0; din_valid = 1'b0; dout_ready = 1'b1;
        test_reset();
        test_key_stream();
        test_wiki();
        test_err();
        test_drop();
        test_w4();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
